regfile_sb: RTL

Parametrised successor to the processor's 32x32 register file. It generalises width and depth and replaces the fixed upper-immediate write with an arbitrary bit-mask write. It adds three things: write-to-read bypass, a per-register scoreboard of pending writebacks for hazard stalls, and a soft-clear sequencer that zeroes the file one register per cycle. It sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_sb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file: masked write with same-cycle bypass, a pending-writeback
// scoreboard for hazard stalls, and a sequencer that soft-clears one register per cycle.
module regfile_sb #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   ws,
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] wmask,
    input  logic            iss_vld,
    input  logic [AW-1:0]   iss_rd,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;

    logic            clearing;
    logic            last;
    logic            wr_en;
    logic            iss_en;
    logic [XLEN-1:0] wr_val;

    assign clearing = (state == CLEAR);
    assign last     = (cnt == AW'(NREGS - 1));
    assign wr_en    = we && (ws != '0) && !clearing;
    assign iss_en   = iss_vld && (iss_rd != '0) && !clearing;
    assign wr_val   = (regs[ws] & ~wmask) | (wd & wmask);
    assign clr_busy = clearing;
    assign dbg_data = regs[dbg_sel];

    // Clear sequencer; cnt holds on the last register rather than wrapping through 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= AW'(1);
                    end
                end
                CLEAR: begin
                    if (last) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register array; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (clearing) begin
            regs[cnt] <= '0;
        end else if (wr_en) begin
            regs[ws] <= wr_val;
        end
    end

    // Scoreboard: a new producer (set) overrides a same-cycle writeback (clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (clearing) begin
            pending[cnt] <= 1'b0;
        end else begin
            if (wr_en) begin
                pending[ws] <= 1'b0;
            end
            if (iss_en) begin
                pending[iss_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1 = regs[rs1];
        if (rs1 == '0) begin
            rd1 = '0;
        end else if (wr_en && (ws == rs1)) begin
            rd1 = wr_val;
        end
    end

    always_comb begin
        rd2 = regs[rs2];
        if (rs2 == '0) begin
            rd2 = '0;
        end else if (wr_en && (ws == rs2)) begin
            rd2 = wr_val;
        end
    end

    // During a clear every source stalls.
    always_comb begin
        rs1_busy = pending[rs1] && !(wr_en && (ws == rs1));
        if (rs1 == '0) begin
            rs1_busy = 1'b0;
        end
        if (clearing) begin
            rs1_busy = 1'b1;
        end
    end

    always_comb begin
        rs2_busy = pending[rs2] && !(wr_en && (ws == rs2));
        if (rs2 == '0) begin
            rs2_busy = 1'b0;
        end
        if (clearing) begin
            rs2_busy = 1'b1;
        end
    end

endmodule
